// File: rtl/seg_display_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// seg_display_ctrl_pkg
// Shared IO header for the eight-digit seven-segment display controller.
// Holds the IO address of the display register, the active-high segment
// patterns for hex digits 0..F in {a,b,c,d,e,f,g,dp} order, the scan index
// type and the leading-zero mask helper.
// Optional feature macro used by the controller: SEG_LZ_BLANK_EN.
// -----------------------------------------------------------------------------
package seg_display_ctrl_pkg;

  // IO-mapped address of the display register as seen by the decode stage.
  localparam logic [31:0] SEG_BASE_ADDR = 32'hFFFF_FC00;

  localparam int DISP_W  = 32;
  localparam int DIGITS  = 8;

  // Segment patterns, bit 7 = a ... bit 1 = g, bit 0 = dp (always 0).
  localparam logic [7:0] SEG_0 = 8'hFC;
  localparam logic [7:0] SEG_1 = 8'h60;
  localparam logic [7:0] SEG_2 = 8'hDA;
  localparam logic [7:0] SEG_3 = 8'hF2;
  localparam logic [7:0] SEG_4 = 8'h66;
  localparam logic [7:0] SEG_5 = 8'hB6;
  localparam logic [7:0] SEG_6 = 8'hBE;
  localparam logic [7:0] SEG_7 = 8'hE0;
  localparam logic [7:0] SEG_8 = 8'hFE;
  localparam logic [7:0] SEG_9 = 8'hF6;
  localparam logic [7:0] SEG_A = 8'hEE;
  localparam logic [7:0] SEG_B = 8'h3E;
  localparam logic [7:0] SEG_C = 8'h9C;
  localparam logic [7:0] SEG_D = 8'h7A;
  localparam logic [7:0] SEG_E = 8'h9E;
  localparam logic [7:0] SEG_F = 8'h8E;
  localparam logic [7:0] SEG_BLANK = 8'h00;

  typedef logic [1:0] scan_idx_t;

  // Bit p set when nibble p and every higher nibble are zero. Digit 0 is
  // never flagged so a zero word still shows a single "0".
  function automatic logic [DIGITS-1:0] lz_blank_mask(input logic [DISP_W-1:0] value);
    logic             all_zero;
    logic [DIGITS-1:0] mask;
    all_zero = 1'b1;
    mask     = '0;
    for (int p = DIGITS - 1; p >= 1; p--) begin
      all_zero = all_zero & (value[4*p +: 4] == 4'h0);
      mask[p]  = all_zero;
    end
    return mask;
  endfunction

endpackage

// File: rtl/seg_display_ctrl_if.sv
// -----------------------------------------------------------------------------
// seg_display_ctrl_if
// Bundles the store strobe/data from the memory/IO decode stage and the
// display outputs of the controller.
//   master : the decode stage side (drives SegCtrl, write_data)
//   slave  : the display controller side (drives segment/digit outputs)
// -----------------------------------------------------------------------------
interface seg_display_ctrl_if;
  import seg_display_ctrl_pkg::*;

  logic              SegCtrl;
  logic [DISP_W-1:0] write_data;
  logic [7:0]        seg_an;
  logic [7:0]        seg_out0;
  logic [7:0]        seg_out1;
  logic [DISP_W-1:0] display_value;

  modport master (
    output SegCtrl,
    output write_data,
    input  seg_an,
    input  seg_out0,
    input  seg_out1,
    input  display_value
  );

  modport slave (
    input  SegCtrl,
    input  write_data,
    output seg_an,
    output seg_out0,
    output seg_out1,
    output display_value
  );

endinterface

// File: rtl/seg_display_ctrl_hex_to_seg7.sv
// -----------------------------------------------------------------------------
// hex_to_seg7
// Purely combinational nibble to seven-segment decoder.
//   nibble : 4-bit hex value
//   seg    : {a,b,c,d,e,f,g,dp}, active-high, dp always 0
// -----------------------------------------------------------------------------
module hex_to_seg7
  import seg_display_ctrl_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [7:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    case (nibble)
      4'h0: seg = SEG_0;
      4'h1: seg = SEG_1;
      4'h2: seg = SEG_2;
      4'h3: seg = SEG_3;
      4'h4: seg = SEG_4;
      4'h5: seg = SEG_5;
      4'h6: seg = SEG_6;
      4'h7: seg = SEG_7;
      4'h8: seg = SEG_8;
      4'h9: seg = SEG_9;
      4'hA: seg = SEG_A;
      4'hB: seg = SEG_B;
      4'hC: seg = SEG_C;
      4'hD: seg = SEG_D;
      4'hE: seg = SEG_E;
      4'hF: seg = SEG_F;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/seg_display_ctrl.sv
// -----------------------------------------------------------------------------
// seg_display_ctrl
// Eight-digit multiplexed seven-segment display controller. A 32-bit word is
// latched from the IO store path and shown as eight hex digits, two at a time
// (digit k on seg_out1 and digit k+4 on seg_out0), scanning k = 0..3.
//
// Parameters
//   SCAN_DIV      : clk cycles per scan position (>= 2)
// Ports
//   clk           : system clock, rising edge
//   rst           : synchronous active-high reset
//   SegCtrl       : store strobe for the display register
//   write_data    : store data
//   seg_an        : digit enables, active-high, bit i = digit i (0 rightmost)
//   seg_out0      : segments for the active digit of 7..4
//   seg_out1      : segments for the active digit of 3..0
//   display_value : currently latched display word
//
// Optional feature: define SEG_LZ_BLANK_EN to blank leading zero digits
// (digit 0 always shows).
// -----------------------------------------------------------------------------
module seg_display_ctrl
  import seg_display_ctrl_pkg::*;
#(
  parameter int SCAN_DIV = 100000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              SegCtrl,
  input  logic [DISP_W-1:0] write_data,
  output logic [7:0]        seg_an,
  output logic [7:0]        seg_out0,
  output logic [7:0]        seg_out1,
  output logic [DISP_W-1:0] display_value
);

  localparam int            PW         = $clog2(SCAN_DIV);
  localparam logic [PW-1:0] PRESC_LAST = PW'(SCAN_DIV - 1);

  logic [DISP_W-1:0] display_q, display_d;
  logic [PW-1:0]     presc_q, presc_d;
  scan_idx_t         scan_idx_q, scan_idx_d;
  logic [7:0]        seg_an_q, seg_an_d;
  logic [7:0]        seg_out0_q, seg_out0_d;
  logic [7:0]        seg_out1_q, seg_out1_d;

  logic              presc_tc;
  logic [4:0]        lo_base, hi_base;
  logic [3:0]        nib_lo, nib_hi;
  logic [7:0]        seg_lo, seg_hi;
  logic [3:0]        an_group;

  // Store path and scan timebase.
  always_comb begin
    display_d  = display_q;
    presc_d    = presc_q + PW'(1);
    scan_idx_d = scan_idx_q;
    presc_tc   = (presc_q == PRESC_LAST);
    if (SegCtrl) begin
      display_d = write_data;
    end
    if (presc_tc) begin
      presc_d    = '0;
      scan_idx_d = scan_idx_q + 2'd1;
    end
  end

  // Nibble selection: low group uses nibble k, high group nibble k+4.
  always_comb begin
    lo_base = {1'b0, scan_idx_q, 2'b00};
    hi_base = {1'b1, scan_idx_q, 2'b00};
    nib_lo  = display_q[lo_base +: 4];
    nib_hi  = display_q[hi_base +: 4];
  end

  hex_to_seg7 u_dec_lo (
    .nibble (nib_lo),
    .seg    (seg_lo)
  );

  hex_to_seg7 u_dec_hi (
    .nibble (nib_hi),
    .seg    (seg_hi)
  );

`ifdef SEG_LZ_BLANK_EN
  logic [DIGITS-1:0] blank_mask;
  always_comb begin
    blank_mask = lz_blank_mask(display_q);
  end
`endif

  // Output stage is computed from the registered word and scan index so the
  // pins follow the state with exactly one cycle of latency.
  always_comb begin
    an_group   = 4'b0001 << scan_idx_q;
    seg_an_d   = {an_group, an_group};
    seg_out1_d = seg_lo;
    seg_out0_d = seg_hi;
`ifdef SEG_LZ_BLANK_EN
    if (blank_mask[{1'b0, scan_idx_q}]) begin
      seg_out1_d = SEG_BLANK;
    end
    if (blank_mask[{1'b1, scan_idx_q}]) begin
      seg_out0_d = SEG_BLANK;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      display_q  <= '0;
      presc_q    <= '0;
      scan_idx_q <= '0;
      seg_an_q   <= '0;
      seg_out0_q <= '0;
      seg_out1_q <= '0;
    end else begin
      display_q  <= display_d;
      presc_q    <= presc_d;
      scan_idx_q <= scan_idx_d;
      seg_an_q   <= seg_an_d;
      seg_out0_q <= seg_out0_d;
      seg_out1_q <= seg_out1_d;
    end
  end

  assign seg_an        = seg_an_q;
  assign seg_out0      = seg_out0_q;
  assign seg_out1      = seg_out1_q;
  assign display_value = display_q;

endmodule
